interval_sched: RTL and testbench

//   Sequencer and configuration front-end for the FP16 score interval classifier.
//   - Holds the NUM-1 programmable FP16 boundaries.
//   - Runs a host-started job of len_i scores through a registered classify

---
 rtl/interval_sched.sv | 161 ++++++++++++++++
 tb/tb_interval_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interval_sched.sv
// -----------------------------------------------------------------------------
// interval_sched
//   Sequencer and configuration front-end for the FP16 score interval
//   classifier. Holds NUM-1 programmable FP16 boundaries, runs a host-started
//   job of len_i scores through a registered classify stage, streams one-hot
//   interval codes downstream and keeps a per-interval histogram of the job.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   cfg_we_i/addr_i/data_i   boundary write port, honoured only when idle
//   start_i, len_i           job start pulse and job length
//   busy_o, done_o           job in progress / one-cycle end-of-job pulse
//   s_valid_i/s_ready_o/s_i  score input stream
//   iv_valid_o/iv_ready_i/iv_o  one-hot interval code output stream
//   hist_idx_i, hist_cnt_o   combinational histogram read
// -----------------------------------------------------------------------------
module interval_sched #(
  parameter int WIDTH = 16,
  parameter int NUM   = 8,
  parameter int CNT_W = 16,
  parameter int LEN_W = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cfg_we_i,
  input  logic [$clog2(NUM-1)-1:0]   cfg_addr_i,
  input  logic [WIDTH-1:0]           cfg_data_i,
  input  logic                       start_i,
  input  logic [LEN_W-1:0]           len_i,
  output logic                       busy_o,
  output logic                       done_o,
  input  logic                       s_valid_i,
  output logic                       s_ready_o,
  input  logic [WIDTH-1:0]           s_i,
  output logic                       iv_valid_o,
  input  logic                       iv_ready_i,
  output logic [NUM-1:0]             iv_o,
  input  logic [$clog2(NUM)-1:0]     hist_idx_i,
  output logic [CNT_W-1:0]           hist_cnt_o
);

  localparam int IW = $clog2(NUM);
  localparam logic [WIDTH-1:0] SIGN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               done_q, done_d;
  logic               iv_valid_q, iv_valid_d;
  logic [NUM-1:0]     iv_q, iv_d;
  logic [WIDTH-1:0]   bnd_q [NUM-1];
  logic [CNT_W-1:0]   hist_q [NUM];

  logic               accept;
  logic               clr_hist;
  logic               cfg_wr;
  logic [IW-1:0]      k_cnt;
  logic [NUM-1:0]     code;
  logic [WIDTH-1:0]   s_key;

  // Maps an FP16 pattern to an unsigned key whose integer order matches the
  // numeric order. -0 is folded onto +0 first so both land in the same bucket.
  function automatic logic [WIDTH-1:0] key_f(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] n;
    n = (x == SIGN) ? '0 : x;
    return n[WIDTH-1] ? ~n : (n | SIGN);
  endfunction

  // Count of boundaries at or below the score; stays one-hot even when the
  // boundaries are not programmed in ascending order.
  always_comb begin
    s_key = key_f(s_i);
    k_cnt = '0;
    for (int j = 0; j < NUM - 1; j++) begin
      if (s_key >= key_f(bnd_q[j])) k_cnt = k_cnt + IW'(1);
    end
    code = {{(NUM-1){1'b0}}, 1'b1} << k_cnt;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    s_ready_o = 1'b0;
    accept    = 1'b0;
    clr_hist  = 1'b0;
    cfg_wr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cfg_wr = cfg_we_i && (int'(cfg_addr_i) < NUM - 1);
        if (start_i) begin
          if (len_i != '0) begin
            state_d  = ST_RUN;
            rem_d    = len_i;
            clr_hist = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        s_ready_o = (rem_q != '0) && (!iv_valid_q || iv_ready_i);
        accept    = s_ready_o && s_valid_i;
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave once the last code has gone (or goes this cycle).
        if (!iv_valid_q || iv_ready_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // 1-deep output register: a new accept overrides the drain of the old code.
    iv_valid_d = accept ? 1'b1 : (iv_ready_i ? 1'b0 : iv_valid_q);
    iv_d       = accept ? code : iv_q;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the boundary and histogram register files are reset too, since
  // both have architecturally visible reset values (unlike a plain RAM).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      done_q     <= 1'b0;
      iv_valid_q <= 1'b0;
      iv_q       <= '0;
      for (int j = 0; j < NUM - 1; j++) bnd_q[j] <= '0;
      for (int i = 0; i < NUM; i++) hist_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      iv_valid_q <= iv_valid_d;
      iv_q       <= iv_d;
      if (cfg_wr) bnd_q[cfg_addr_i] <= cfg_data_i;
      if (clr_hist) begin
        for (int i = 0; i < NUM; i++) hist_q[i] <= '0;
      end else if (accept && (hist_q[k_cnt] != '1)) begin
        hist_q[k_cnt] <= hist_q[k_cnt] + CNT_W'(1);
      end
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign iv_valid_o = iv_valid_q;
  assign iv_o       = iv_q;
  assign hist_cnt_o = hist_q[hist_idx_i];

endmodule

// File: tb/tb_interval_sched.sv
// -----------------------------------------------------------------------------
// tb_interval_sched
//   Directed bench for interval_sched. A numeric model (FP16 decoded to real)
//   predicts every output each cycle; directed literal checks pin the model.
//   A second instance with CNT_W=2 shares all inputs to exercise saturation.
// -----------------------------------------------------------------------------
module tb_interval_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_we_i;
  logic [2:0]  cfg_addr_i;
  logic [15:0] cfg_data_i;
  logic        start_i;
  logic [11:0] len_i;
  logic        s_valid_i;
  logic [15:0] s_i;
  logic        iv_ready_i;
  logic [2:0]  hist_idx_i;

  logic        busy_o, done_o, s_ready_o, iv_valid_o;
  logic [7:0]  iv_o;
  logic [15:0] hist_cnt_o;
  logic        busy2, done2, s_ready2, iv_valid2;
  logic [7:0]  iv2;
  logic [1:0]  hist2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rx [$];

  interval_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .start_i(start_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_i(s_i),
    .iv_valid_o(iv_valid_o), .iv_ready_i(iv_ready_i), .iv_o(iv_o),
    .hist_idx_i(hist_idx_i), .hist_cnt_o(hist_cnt_o)
  );

  interval_sched #(.CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .start_i(start_i), .len_i(len_i), .busy_o(busy2), .done_o(done2),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready2), .s_i(s_i),
    .iv_valid_o(iv_valid2), .iv_ready_i(iv_ready_i), .iv_o(iv2),
    .hist_idx_i(hist_idx_i), .hist_cnt_o(hist2)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic real fp2r(input logic [15:0] x);
    int  e;
    int  sh;
    real r;
    e  = int'(x[14:10]);
    r  = real'(x[9:0]) + ((e == 0) ? 0.0 : 1024.0);
    sh = ((e == 0) ? 1 : e) - 25;
    for (int i = 0; i < sh; i++) r = r * 2.0;
    for (int i = 0; i < -sh; i++) r = r / 2.0;
    return x[15] ? -r : r;
  endfunction

  logic [15:0] m_bnd [7];
  int          m_hist [8];
  logic        m_busy, m_drain, m_valid, m_done;
  logic [7:0]  m_code;
  int          m_rem;
  logic        m_sready, m_accept;

  function automatic int model_k(input logic [15:0] s);
    int k = 0;
    for (int j = 0; j < 7; j++) if (fp2r(s) >= fp2r(m_bnd[j])) k++;
    return k;
  endfunction

  assign m_sready = m_busy && !m_drain && (m_rem != 0) && (!m_valid || iv_ready_i);
  assign m_accept = m_sready && s_valid_i;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy <= 0; m_drain <= 0; m_valid <= 0; m_done <= 0; m_code <= '0; m_rem <= 0;
      for (int j = 0; j < 7; j++) m_bnd[j] <= '0;
      for (int i = 0; i < 8; i++) m_hist[i] <= 0;
    end else begin
      m_done <= 0;
      if (!m_busy) begin
        if (cfg_we_i && cfg_addr_i < 3'd7) m_bnd[cfg_addr_i] <= cfg_data_i;
        if (start_i) begin
          if (len_i != 0) begin
            m_busy <= 1; m_drain <= 0; m_rem <= int'(len_i);
            for (int i = 0; i < 8; i++) m_hist[i] <= 0;
          end else m_done <= 1;
        end
      end else if (!m_drain) begin
        if (m_accept) begin
          m_rem <= m_rem - 1;
          m_hist[model_k(s_i)] <= m_hist[model_k(s_i)] + 1;
          if (m_rem == 1) m_drain <= 1;
        end
      end else if (!m_valid || iv_ready_i) begin
        m_busy <= 0; m_drain <= 0; m_done <= 1;
      end
      if (m_accept) begin
        m_valid <= 1;
        m_code  <= 8'(1) << model_k(s_i);
      end else if (iv_ready_i) m_valid <= 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    int h;
    h = m_hist[hist_idx_i];
    check("busy", busy_o, m_busy);
    check("done", done_o, m_done);
    check("s_ready", s_ready_o, m_sready);
    check("iv_valid", iv_valid_o, m_valid);
    if (m_valid) check("iv_o", iv_o, m_code);
    check("hist", hist_cnt_o, (h > 65535) ? 65535 : h);
    check("hist_sat", hist2, (h > 3) ? 3 : h);
    check("iv_valid2", iv_valid2, m_valid);
    if (m_valid) check("iv_o2", iv2, m_code);
    if (iv_valid_o && iv_ready_i) rx.push_back(iv_o);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_bnd(input logic [2:0] a, input logic [15:0] d);
    cfg_we_i = 1; cfg_addr_i = a; cfg_data_i = d;
    tick();
    cfg_we_i = 0;
  endtask

  task automatic start_job(input logic [11:0] n);
    start_i = 1; len_i = n;
    tick();
    start_i = 0;
  endtask

  task automatic send(input logic [15:0] v);
    bit ok = 0;
    s_valid_i = 1; s_i = v; hist_idx_i = 3'($urandom_range(0, 7));
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      ok = s_ready_o;
      @(posedge clk_i);
      #1;
    end
    s_valid_i = 0;
    check("send_accepted", ok, 1);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done_o) seen = 1;
      else tick();
    end
    check("done_seen", seen, 1);
  endtask

  task automatic check_rx(input string nm, input logic [7:0] e [8], input int n);
    check({nm, "_count"}, rx.size(), n);
    for (int i = 0; i < n; i++) check(nm, (i < rx.size()) ? rx[i] : 8'hxx, e[i]);
  endtask

  task automatic check_hist(input logic [2:0] idx, input int exp);
    hist_idx_i = idx;
    #1;
    check("hist_lit", hist_cnt_o, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] sc1 [8];
    logic [15:0] sc3 [6];
    logic [7:0]  stall_code;
    int          tot;
    sc1 = '{16'hC000, 16'hBA00, 16'hB400, 16'h3400, 16'h3A00, 16'h3E00, 16'h4200, 16'h4800};
    sc3 = '{16'h4400, 16'hC000, 16'h3800, 16'h3C00, 16'h0000, 16'h4400};
    rst_ni = 0; cfg_we_i = 0; cfg_addr_i = 0; cfg_data_i = 0; start_i = 0; len_i = 0;
    s_valid_i = 0; s_i = 0; iv_ready_i = 1; hist_idx_i = 0;
    repeat (3) tick();
    rst_ni = 1;
    tick();

    // Reset state
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_sready", s_ready_o, 0);
    check("rst_ivvalid", iv_valid_o, 0);
    check("rst_iv", iv_o, 0);
    check_hist(3'd5, 0);

    // 1: standard bucketing across all eight intervals
    write_bnd(0, 16'hBC00); write_bnd(1, 16'hB800); write_bnd(2, 16'h0000);
    write_bnd(3, 16'h3800); write_bnd(4, 16'h3C00); write_bnd(5, 16'h4000);
    write_bnd(6, 16'h4400);
    rx.delete();
    start_job(8);
    check("t1_busy", busy_o, 1);
    for (int i = 0; i < 8; i++) send(sc1[i]);
    check("t1_done_early", done_o, 0);
    tick();
    check("t1_done", done_o, 1);
    check("t1_idle", busy_o, 0);
    tick();
    check("t1_done_pulse", done_o, 0);
    check_rx("t1_codes", '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80}, 8);
    for (int i = 0; i < 8; i++) check_hist(3'(i), 1);
    tick();

    // 2: -0 sorts as +0, landing at or above b2 = 0
    rx.delete();
    start_job(2);
    send(16'h8000);
    send(16'h0000);
    wait_done();
    check_rx("t2_negzero", '{8'h08, 8'h08, 0, 0, 0, 0, 0, 0}, 2);
    check_hist(3'd3, 2);
    tick();

    // 3: five cycles of downstream backpressure mid-job
    rx.delete();
    start_job(6);
    fork
      begin
        for (int i = 0; i < 6; i++) send(sc3[i]);
      end
      begin
        repeat (3) tick();
        iv_ready_i = 0;
        stall_code = iv_o;
        repeat (5) begin
          @(negedge clk_i);
          check("t3_sready", s_ready_o, 0);
          check("t3_valid", iv_valid_o, 1);
          check("t3_hold", iv_o, stall_code);
          @(posedge clk_i);
          #1;
        end
        iv_ready_i = 1;
      end
    join
    wait_done();
    check_rx("t3_codes", '{8'h80, 8'h01, 8'h10, 8'h20, 8'h08, 8'h80, 0, 0}, 6);
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      hist_idx_i = 3'(i);
      #1;
      tot += int'(hist_cnt_o);
    end
    check("t3_hist_total", tot, 6);
    check_hist(3'd7, 2);
    tick();

    // 4: config write and start while busy are ignored
    rx.delete();
    start_job(2);
    cfg_we_i = 1; cfg_addr_i = 0; cfg_data_i = 16'hC400;
    start_i = 1; len_i = 5;
    tick();
    cfg_we_i = 0; start_i = 0;
    send(16'hC000);
    send(16'h3400);
    wait_done();
    tick(); tick();
    check("t4_no_restart", busy_o, 0);
    check_rx("t4_codes", '{8'h01, 8'h08, 0, 0, 0, 0, 0, 0}, 2);
    // write and start together: the job sees the new boundary
    rx.delete();
    cfg_we_i = 1; cfg_addr_i = 6; cfg_data_i = 16'h4800;
    start_job(1);
    cfg_we_i = 0;
    send(16'h4600);
    wait_done();
    check_rx("t4_same_cycle", '{8'h40, 0, 0, 0, 0, 0, 0, 0}, 1);
    tick();
    write_bnd(6, 16'h4400);
    // zero-length job
    start_job(0);
    check("t4_len0_done", done_o, 1);
    check("t4_len0_busy", busy_o, 0);
    tick();
    check("t4_len0_pulse", done_o, 0);
    check("t4_len0_busy2", busy_o, 0);

    // 5: histogram saturation on the CNT_W=2 instance
    rx.delete();
    start_job(5);
    repeat (5) send(16'hC000);
    wait_done();
    hist_idx_i = 0;
    #1;
    check("t5_hist_wide", hist_cnt_o, 5);
    check("t5_hist_sat", hist2, 3);
    tick();

    // 6: async reset mid-job with a code held in the output register
    iv_ready_i = 0;
    start_job(4);
    send(16'h3800);
    hist_idx_i = 4;
    #1;
    check("t6_pre_valid", iv_valid_o, 1);
    check("t6_pre_hist", hist_cnt_o, 1);
    #1;
    rst_ni = 0;
    #1;
    check("t6_busy", busy_o, 0);
    check("t6_done", done_o, 0);
    check("t6_sready", s_ready_o, 0);
    check("t6_ivvalid", iv_valid_o, 0);
    check("t6_iv", iv_o, 0);
    check("t6_hist", hist_cnt_o, 0);
    iv_ready_i = 1;
    tick(); tick();
    rst_ni = 1;
    tick();
    rx.delete();
    start_job(2);
    send(16'h3C00);
    send(16'hBC00);
    wait_done();
    check_rx("t6_codes", '{8'h80, 8'h01, 0, 0, 0, 0, 0, 0}, 2);
    check_hist(3'd7, 1);
    check_hist(3'd0, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
